// File: rtl/mcore_pkg.sv
// Shared mcore definitions: address utilities and the bit-fetch state encoding.
package mcore_pkg;

    localparam int unsigned M_UTIL_ADDR_WORD_BYTES = 4;
    localparam int unsigned M_UTIL_ADDR_ALIGN_MASK = 3;

    typedef enum logic [1:0] {
        BF_IDLE  = 2'd0,
        BF_FETCH = 2'd1,
        BF_ERR   = 2'd2
    } bitfetch_state_e;

endpackage

// File: rtl/mcore_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and synchronous clear.
module mcore_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full && !i_clr;
    assign w_do_pop  = i_pop && !o_empty && !i_clr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    // Upstream flow control keeps the FIFO from ever being offered a word while full.
    a_no_push_full: assert property (@(posedge aclk) disable iff (!aresetn) !(i_push && o_full));

endmodule

// File: rtl/mcore_bitfetch.sv
// Word prefetcher for the bit reader: streams consecutive memory words of a buffer into a FWFT FIFO.
module mcore_bitfetch
    import mcore_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic                    stop,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rsp_valid,
    input  logic                    mem_rsp_error,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
    output logic                    word_valid,
    output logic [DATA_WIDTH-1:0]   word_data,
    input  logic                    word_ready,
    output logic                    busy,
    output logic                    error
);

    localparam int CW = $clog2(DEPTH) + 1;

    bitfetch_state_e       r_state;
    bitfetch_state_e       w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_discard;
    logic [CW-1:0]         w_out_nxt;
    logic [CW-1:0]         w_fifo_count;
    logic                  r_error;
    logic                  w_grant;
    logic                  w_rsp;
    logic                  w_rsp_live;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rsp_err;
    logic                  w_room;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

    assign mem_we    = 1'b0;
    assign mem_wdata = '0;
    assign mem_be    = '1;
    assign mem_addr  = r_addr;
    assign busy      = (r_state != BF_IDLE);
    assign error     = r_error;

    assign w_room  = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign mem_req = (r_state == BF_FETCH) && (r_discard == '0) && w_room;
    assign w_grant = mem_req && mem_gnt;

    // A response with nothing in flight (e.g. right after reset) is not ours to count.
    assign w_rsp      = mem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_live = w_rsp && (r_discard == '0) && (r_state == BF_FETCH) && !start && !stop;
    assign w_push     = w_rsp_live && !mem_rsp_error;
    assign w_rsp_err  = w_rsp_live && mem_rsp_error;
    assign w_out_nxt  = r_outstanding + CW'(w_grant) - CW'(w_rsp);

    assign word_valid = !w_fifo_empty;
    assign w_pop      = word_valid && word_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = BF_FETCH;
        end else begin
            case (r_state)
                BF_FETCH: begin
                    if (stop)           w_state_nxt = BF_IDLE;
                    else if (w_rsp_err) w_state_nxt = BF_ERR;
                end
                BF_ERR: begin
                    if (stop) w_state_nxt = BF_IDLE;
                end
                BF_IDLE: w_state_nxt = BF_IDLE;
                default: w_state_nxt = BF_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= BF_IDLE;
            r_addr        <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;

            if (start)        r_addr <= start_addr & ~ADDR_WIDTH'(M_UTIL_ADDR_ALIGN_MASK);
            else if (w_grant) r_addr <= r_addr + ADDR_WIDTH'(M_UTIL_ADDR_WORD_BYTES);

            // Everything still in flight after a start/stop belongs to the abandoned buffer.
            if (start || stop)                  r_discard <= w_out_nxt;
            else if (w_rsp && r_discard != '0)  r_discard <= r_discard - 1'b1;

            if (start)          r_error <= 1'b0;
            else if (w_rsp_err) r_error <= 1'b1;
        end
    end

    mcore_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_clr   (start),
        .i_push  (w_push),
        .i_wdata (mem_rsp_rdata),
        .i_pop   (w_pop),
        .o_rdata (word_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    a_push_not_full: assert property (@(posedge aclk) disable iff (!aresetn) !(w_push && w_fifo_full));

endmodule
